// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer slice.
// Holds the sequencer state encoding and the default word width and FIFO depth
// used by spi_sync_fifo and spi_xfer_sequencer.
package spi_pkg;

  // Default word width; must match the WIDTH of the attached SPI master.
  localparam int unsigned SPI_WIDTH_DEF = 8;

  // Default FIFO depth (power of two, at least 2).
  localparam int unsigned SPI_DEPTH_DEF = 4;

  // Sequencer states. The encoding is fixed so it can be matched in debug dumps.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LAUNCH    = 2'b01,
    ST_WAIT_DONE = 2'b10,
    ST_GAP       = 2'b11
  } seq_state_e;

  // Width of a FIFO occupancy counter that must be able to hold the value DEPTH.
  function automatic int unsigned fifo_level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO used for both the TX and RX word queues.
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   push_i, wdata_i    write request and data; ignored while full
//   pop_i              read request; ignored while empty
//   rdata_o            word at the head of the queue
//   full_o, empty_o    occupancy flags
//   level_o            number of stored words (0..DEPTH)
// A push into an empty FIFO is only visible on rdata_o the cycle after the
// push edge (no read-through); a push into a full FIFO is dropped, so the
// owner must gate it with !full_o (no write-through).
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH_DEF,
  parameter int unsigned DEPTH = SPI_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == {LVL_W{1'b0}});
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rptr_q];
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok_s) begin
      wptr_d = wptr_q + PTR_W'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_ok_s) begin
      rptr_d = rptr_q + PTR_W'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage and pointer registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
      level_q <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wptr_q] <= wdata_i;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Sequencer sitting in front of an SPI master.
// Host side:
//   tx_data/tx_valid/tx_ready   words to send (valid/ready, buffered in TX FIFO)
//   rx_data/rx_valid/rx_ready   received words (valid/ready, from RX FIFO)
//   tx_level, rx_level          FIFO occupancies
//   idle                        in IDLE with nothing queued for transmission
// Master side:
//   m_start/m_data_in           one-cycle launch pulse and the word to shift out
//   m_busy/m_done/m_data_out    master status, completion pulse and received word
// One frame is launched per TX word. A frame is only launched when the RX FIFO
// has a free slot; since only one frame is ever in flight and this block is the
// sole RX writer, the RX push on m_done can never overflow. After each frame a
// minimum of GAP_CYCLES clocks elapse before the next m_start.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH      = SPI_WIDTH_DEF,
  parameter int unsigned DEPTH      = SPI_DEPTH_DEF,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   m_start,
  output logic [WIDTH-1:0]       m_data_in,
  input  logic                   m_busy,
  input  logic                   m_done,
  input  logic [WIDTH-1:0]       m_data_out,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   idle
);

  // Gap counter must hold GAP_CYCLES; keep at least one bit when the gap is 0 or 1.
  localparam int unsigned GAP_W = (GAP_CYCLES < 32'd2) ? 1 : $clog2(GAP_CYCLES + 1);

  seq_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             m_start_q, m_start_d;
  logic [WIDTH-1:0] m_data_in_q, m_data_in_d;

  logic [WIDTH-1:0] tx_head_s;
  logic             tx_full_s;
  logic             tx_empty_s;
  logic             tx_pop_s;
  logic             rx_full_s;
  logic             rx_empty_s;
  logic             rx_push_s;

  spi_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (tx_pop_s),
    .rdata_o (tx_head_s),
    .full_o  (tx_full_s),
    .empty_o (tx_empty_s),
    .level_o (tx_level)
  );

  spi_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_push_s),
    .wdata_i (m_data_out),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .full_o  (rx_full_s),
    .empty_o (rx_empty_s),
    .level_o (rx_level)
  );

  assign tx_ready  = !tx_full_s;
  assign rx_valid  = !rx_empty_s;
  assign m_start   = m_start_q;
  assign m_data_in = m_data_in_q;
  assign idle      = (state_q == ST_IDLE) && tx_empty_s;

  // Frame sequencing: launch, wait for completion, then enforce the CS-high gap.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    m_start_d   = 1'b0;
    m_data_in_d = m_data_in_q;
    tx_pop_s    = 1'b0;
    rx_push_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // RX slot is reserved here so the later m_done push always fits.
        if (!tx_empty_s && !rx_full_s && !m_busy) begin
          m_start_d   = 1'b1;
          m_data_in_d = tx_head_s;
          tx_pop_s    = 1'b1;
          state_d     = ST_LAUNCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (m_done) begin
          rx_push_s = 1'b1;
          if (GAP_CYCLES == 32'd0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = GAP_W'(GAP_CYCLES);
            state_d = ST_GAP;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = {GAP_W{1'b0}};
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_q - GAP_W'(1);
          state_d = ST_GAP;
        end
      end
      default: begin
        gap_d   = {GAP_W{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and master-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gap_q       <= {GAP_W{1'b0}};
      m_start_q   <= 1'b0;
      m_data_in_q <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      m_start_q   <= m_start_d;
      m_data_in_q <= m_data_in_d;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer with a behavioural SPI master and
// queue-based reference model (TX queue, RX queue, frame/gap bookkeeping).
module tb_spi_xfer_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             m_start;
  logic [WIDTH-1:0] m_data_in;
  logic             m_busy;
  logic             m_done;
  logic [WIDTH-1:0] m_data_out;
  logic [LW-1:0]    tx_level;
  logic [LW-1:0]    rx_level;
  logic             idle;

  spi_xfer_sequencer #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_busy     (m_busy),
    .m_done     (m_done),
    .m_data_out (m_data_out),
    .tx_level   (tx_level),
    .rx_level   (rx_level),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] tx_src[$];    // words waiting to be offered on tx_valid
  logic [7:0] tx_model[$];  // words accepted into TX, not yet launched
  logic [7:0] rx_model[$];  // words received, not yet consumed

  int         rx_mode     = 0;  // 0: never ready, 1: always ready, 2: random
  bit         tx_rand     = 0;
  bit         in_flight   = 0;
  int         busy_cnt    = 0;
  int         extra_busy  = 0;
  bit         force_resp  = 0;
  logic [7:0] forced_word = 8'h00;
  logic [7:0] last_word   = 8'h00;
  bit         done_seen   = 0;
  int         done_edge   = 0;
  int         frames      = 0;
  int         prev_rx_lvl = 0;
  int         push_edge   = 0;
  bit         lat_check   = 0;
  int         f0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge, check against the model, then drive.
  task automatic tick();
    bit         started;
    bit         rdy;
    logic [7:0] w;
    @(posedge clk);
    #1;
    cyc++;
    started = (m_start === 1'b1);
    if (started) begin
      chk("start_while_busy", {31'd0, in_flight}, 32'd0);
      chk("launch_rx_space", {31'd0, (prev_rx_lvl < DEPTH)}, 32'd1);
      if (done_seen) chk("gap_after_done", {31'd0, ((cyc - done_edge) >= GAP + 1)}, 32'd1);
      if (lat_check) begin
        chk("launch_latency", cyc, push_edge + 1);
        lat_check = 0;
      end
      if (tx_model.size() > 0) begin
        w = tx_model.pop_front();
        chk("m_data_in", {24'd0, m_data_in}, {24'd0, w});
        last_word = w;
      end else begin
        chk("spurious_start", tx_model.size(), 32'd1);
      end
      frames++;
    end
    chk("m_data_in_hold", {24'd0, m_data_in}, {24'd0, last_word});
    if (done_seen && cyc == done_edge) chk("rx_valid_after_done", {31'd0, rx_valid}, 32'd1);
    chk("tx_level", {29'd0, tx_level}, tx_model.size());
    chk("rx_level", {29'd0, rx_level}, rx_model.size());
    chk("tx_ready", {31'd0, tx_ready}, {31'd0, (tx_model.size() < DEPTH)});
    chk("rx_valid", {31'd0, rx_valid}, {31'd0, (rx_model.size() > 0)});
    prev_rx_lvl = rx_model.size();

    // behavioural master
    m_done = 1'b0;
    if (started) begin
      in_flight = 1;
      m_busy    = 1'b1;
      busy_cnt  = int'($urandom_range(3, 0)) + extra_busy;
    end else if (in_flight) begin
      if (busy_cnt == 0) begin
        w          = force_resp ? forced_word : 8'($urandom);
        force_resp = 0;
        m_data_out = w;
        m_done     = 1'b1;
        m_busy     = 1'b0;
        rx_model.push_back(w);
        in_flight  = 0;
        done_seen  = 1;
        done_edge  = cyc + 1;
      end else begin
        busy_cnt--;
      end
    end else begin
      m_busy = 1'b0;
    end

    // RX consumer
    rdy = (rx_mode == 1) || (rx_mode == 2 && $urandom_range(1, 0) == 1);
    rx_ready = rdy;
    if (rdy && rx_valid === 1'b1 && rx_model.size() > 0) begin
      w = rx_model.pop_front();
      chk("rx_data", {24'd0, rx_data}, {24'd0, w});
    end

    // TX producer
    if (tx_src.size() > 0 && (!tx_rand || $urandom_range(1, 0) == 1)) begin
      tx_valid = 1'b1;
      tx_data  = tx_src[0];
      if (tx_ready === 1'b1) begin
        tx_model.push_back(tx_src.pop_front());
        push_edge = cyc + 1;
      end
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((tx_src.size() > 0 || tx_model.size() > 0 || rx_model.size() > 0 || in_flight) && k < budget) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, (k < budget)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_start"}, {31'd0, m_start}, 32'd0);
    chk({tag, "_m_data_in"}, {24'd0, m_data_in}, 32'd0);
    chk({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    chk({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    chk({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
    chk({tag, "_tx_level"}, {29'd0, tx_level}, 32'd0);
    chk({tag, "_rx_level"}, {29'd0, rx_level}, 32'd0);
    chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0;
    m_busy = 1'b0; m_done = 1'b0; m_data_out = 8'h00;

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      tx_valid = 1'($urandom); tx_data = 8'($urandom); rx_ready = 1'($urandom);
      m_busy = 1'($urandom); m_done = 1'($urandom); m_data_out = 8'($urandom);
      check_reset_outputs("reset");
    end
    tx_valid = 1'b0; rx_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(6);
    chk("idle_after_reset", {31'd0, idle}, 32'd1);

    // Single frame with fixed loopback reply.
    f0 = frames;
    force_resp = 1; forced_word = 8'h3C; lat_check = 1;
    tx_src.push_back(8'hA5);
    rx_mode = 0;
    begin
      int k = 0;
      while ((rx_model.size() == 0 || in_flight) && k < 40) begin tick(); k++; end
      chk("single_timeout", {31'd0, (k < 40)}, 32'd1);
    end
    run(2);
    chk("single_frames", frames - f0, 32'd1);
    chk("single_rx_data", {24'd0, rx_data}, 32'h3C);
    rx_mode = 1;
    drain("single_drain", 40);

    // Back-to-back burst, gap enforced between frames.
    f0 = frames;
    for (int i = 1; i <= 4; i++) tx_src.push_back(8'(i));
    drain("burst_drain", 200);
    chk("burst_frames", frames - f0, 32'd4);

    // RX backpressure stalls the fifth frame until one word is consumed.
    f0 = frames;
    rx_mode = 0;
    for (int i = 0; i < 5; i++) tx_src.push_back(8'($urandom));
    run(80);
    chk("bp_frames", frames - f0, 32'd4);
    chk("bp_tx_level", {29'd0, tx_level}, 32'd1);
    chk("bp_rx_level", {29'd0, rx_level}, 32'd4);
    chk("bp_idle", {31'd0, idle}, 32'd0);
    rx_mode = 1; tick(); rx_mode = 0;
    run(30);
    chk("bp_fifth_frame", frames - f0, 32'd5);
    rx_mode = 1;
    drain("bp_drain", 200);

    // Fill TX to DEPTH, then launch (pop) while a push is pending on a full FIFO.
    rx_mode = 0;
    for (int i = 0; i < 4; i++) tx_src.push_back(8'($urandom));
    run(60);
    for (int i = 0; i < 5; i++) tx_src.push_back(8'($urandom));
    run(10);
    chk("full_tx_level", {29'd0, tx_level}, 32'd4);
    chk("full_tx_ready", {31'd0, tx_ready}, 32'd0);
    chk("full_pending", tx_src.size(), 32'd1);
    rx_mode = 1; tick(); rx_mode = 0;
    run(20);
    chk("full_refill_level", {29'd0, tx_level}, 32'd4);
    chk("full_pending_taken", tx_src.size(), 32'd0);
    rx_mode = 1;
    drain("full_drain", 400);
    run(8);  // rx_ready held with RX empty: pops must have no effect
    chk("empty_idle", {31'd0, idle}, 32'd1);

    // Randomised traffic with random gaps and backpressure.
    tx_rand = 1; rx_mode = 2;
    for (int i = 0; i < 20; i++) tx_src.push_back(8'($urandom));
    drain("rand_drain", 800);
    tx_rand = 0; rx_mode = 1;

    // Reset in the middle of a frame with two words queued.
    extra_busy = 6;
    for (int i = 0; i < 3; i++) tx_src.push_back(8'($urandom));
    begin
      int k = 0;
      while (!(in_flight && tx_src.size() == 0 && tx_model.size() == 2) && k < 40) begin tick(); k++; end
      chk("midreset_setup", {31'd0, (k < 40)}, 32'd1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tx_src.delete(); tx_model.delete(); rx_model.delete();
    in_flight = 0; extra_busy = 0; done_seen = 0; last_word = 8'h00; prev_rx_lvl = 0;
    m_busy = 1'b0; m_done = 1'b0; tx_valid = 1'b0;
    run(3);
    rst_n = 1'b1;
    f0 = frames;
    run(15);
    chk("midreset_no_stale", frames - f0, 32'd0);
    chk("midreset_idle", {31'd0, idle}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
